// File: rtl/plc_ctrl.sv
// plc_ctrl: control/status register block for the PLC BPSK modem.
// A 32-bit word-addressed slave bus loads the TX byte, starts a transmission,
// sets the symbol-rate divisor and collects received bytes. Drives modem
// TX/RX control and a level interrupt on TX completion / RX arrival.
//
// Ports:
//   BusClk, BusReset            clock, synchronous active-high reset
//   BusAddress[5:0]             word address
//   BusByteEnable[3:0]          write byte lanes
//   BusWriteData[31:0]          write data
//   BusWrite, BusRead           access strobes
//   BusReadData[31:0]           registered read data
//   Irq                         level interrupt
//   TxByte[7:0], TxStart        modem TX byte and one-cycle start pulse
//   TxBusy                      modem TX busy (external)
//   RxByte[7:0], RxValid        modem RX byte and strobe
//   ModemEnable, SymbolDiv      CTRL.ENABLE and DIVISOR
module plc_ctrl #(
  parameter logic [15:0] DIV_RESET = 16'd100,
  parameter logic [31:0] VERSION   = 32'h504C0001
) (
  input  logic        BusClk,
  input  logic        BusReset,
  input  logic [5:0]  BusAddress,
  input  logic [3:0]  BusByteEnable,
  input  logic [31:0] BusWriteData,
  input  logic        BusWrite,
  input  logic        BusRead,
  output logic [31:0] BusReadData,
  output logic        Irq,
  output logic [7:0]  TxByte,
  output logic        TxStart,
  input  logic        TxBusy,
  input  logic [7:0]  RxByte,
  input  logic        RxValid,
  output logic        ModemEnable,
  output logic [15:0] SymbolDiv
);

  logic        r_enable, r_ie_tx, r_ie_rx;
  logic [7:0]  r_txdata;
  logic        r_tx_done, r_rx_valid, r_rx_overrun, r_tx_coll;
  logic [7:0]  r_rxdata;
  logic [15:0] r_div;
  logic        r_txbusy_q;
  logic        r_tx_start;
  logic [31:0] r_rdata;

  logic        w_wr_ctrl, w_wr_txdata, w_wr_status, w_wr_div;
  logic        w_start;
  logic [4:1]  w_status_clr;
  logic        w_rxdata_rd;
  logic        w_tx_done_set;
  logic [31:0] w_rd_val;
  logic        w_unused;

  // Only the low two lanes carry writable bits anywhere in the map.
  assign w_unused = ^{BusWriteData[31:16], BusByteEnable[3:2]};

  assign w_wr_ctrl     = BusWrite && (BusAddress == 6'd0);
  assign w_wr_txdata   = BusWrite && (BusAddress == 6'd1);
  assign w_wr_status   = BusWrite && (BusAddress == 6'd2);
  assign w_wr_div      = BusWrite && (BusAddress == 6'd4);
  assign w_start       = w_wr_ctrl && BusByteEnable[0] && BusWriteData[0];
  assign w_status_clr  = (w_wr_status && BusByteEnable[0]) ? BusWriteData[4:1] : 4'b0;
  assign w_rxdata_rd   = BusRead && (BusAddress == 6'd3);
  assign w_tx_done_set = r_txbusy_q && !TxBusy;

  // Read mux sees pre-write register state, so a same-cycle read/write
  // returns the old value.
  always_comb begin
    w_rd_val = 32'b0;
    case (BusAddress)
      6'd0:    w_rd_val = {28'b0, r_ie_rx, r_ie_tx, r_enable, 1'b0};
      6'd1:    w_rd_val = {24'b0, r_txdata};
      6'd2:    w_rd_val = {27'b0, r_tx_coll, r_rx_overrun, r_rx_valid, r_tx_done, TxBusy};
      6'd3:    w_rd_val = {24'b0, r_rxdata};
      6'd4:    w_rd_val = {16'b0, r_div};
      6'd5:    w_rd_val = VERSION;
      default: w_rd_val = 32'b0;
    endcase
  end

  always_ff @(posedge BusClk) begin
    if (BusReset) begin
      r_enable     <= 1'b0;
      r_ie_tx      <= 1'b0;
      r_ie_rx      <= 1'b0;
      r_txdata     <= 8'b0;
      r_tx_done    <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_tx_coll    <= 1'b0;
      r_rxdata     <= 8'b0;
      r_div        <= DIV_RESET;
      r_txbusy_q   <= 1'b0;
      r_tx_start   <= 1'b0;
      r_rdata      <= 32'b0;
    end else begin
      r_txbusy_q <= TxBusy;
      r_tx_start <= w_start && !TxBusy;

      if (w_wr_ctrl && BusByteEnable[0]) begin
        r_enable <= BusWriteData[1];
        r_ie_tx  <= BusWriteData[2];
        r_ie_rx  <= BusWriteData[3];
      end
      if (w_wr_txdata && BusByteEnable[0]) r_txdata <= BusWriteData[7:0];
      if (w_wr_div && BusByteEnable[0]) r_div[7:0]  <= BusWriteData[7:0];
      if (w_wr_div && BusByteEnable[1]) r_div[15:8] <= BusWriteData[15:8];

      // Sticky flags: a set event in the same cycle as a clear wins.
      r_tx_done    <= w_tx_done_set | (r_tx_done & !w_status_clr[1]);
      r_rx_valid   <= RxValid | (r_rx_valid & !w_status_clr[2] & !w_rxdata_rd);
      r_rx_overrun <= (RxValid & r_rx_valid) | (r_rx_overrun & !w_status_clr[3]);
      r_tx_coll    <= (w_start & TxBusy) | (r_tx_coll & !w_status_clr[4]);

      if (RxValid) r_rxdata <= RxByte;
      if (BusRead) r_rdata  <= w_rd_val;
    end
  end

  assign BusReadData = r_rdata;
  assign TxStart     = r_tx_start;
  assign TxByte      = r_txdata;
  assign ModemEnable = r_enable;
  assign SymbolDiv   = r_div;
  assign Irq         = (r_tx_done & r_ie_tx) | (r_rx_valid & r_ie_rx);

endmodule

// File: tb/tb_plc_ctrl.sv
// Bench for plc_ctrl: directed vector table followed by randomized traffic
// checked against a register-map level reference model.
module tb_plc_ctrl;

  localparam logic [31:0] VER = 32'h504C0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wd = '0;
  logic        wr = 1'b0, rd = 1'b0;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  txbyte;
  logic        txstart;
  logic        busy = 1'b0;
  logic [7:0]  rxb = '0;
  logic        rxv = 1'b0;
  logic        men;
  logic [15:0] sdiv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  plc_ctrl dut (
    .BusClk       (clk),
    .BusReset     (rst),
    .BusAddress   (addr),
    .BusByteEnable(be),
    .BusWriteData (wd),
    .BusWrite     (wr),
    .BusRead      (rd),
    .BusReadData  (rdata),
    .Irq          (irq),
    .TxByte       (txbyte),
    .TxStart      (txstart),
    .TxBusy       (busy),
    .RxByte       (rxb),
    .RxValid      (rxv),
    .ModemEnable  (men),
    .SymbolDiv    (sdiv)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, wr, rd;
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        busy, rxv;
    logic [7:0]  rxb;
    logic [31:0] e_rd;
    logic        e_ts, e_irq;
    logic [7:0]  e_txb;
  } vec_t;

  function automatic vec_t v(input logic r, input logic w, input logic d, input logic [5:0] a,
                             input logic [3:0] b, input logic [31:0] x, input logic bz,
                             input logic rv, input logic [7:0] rb, input logic [31:0] er,
                             input logic ets, input logic ei, input logic [7:0] etb);
    vec_t t;
    t.rst = r; t.wr = w; t.rd = d; t.addr = a; t.be = b; t.wd = x; t.busy = bz;
    t.rxv = rv; t.rxb = rb; t.e_rd = er; t.e_ts = ets; t.e_irq = ei; t.e_txb = etb;
    return t;
  endfunction

  // Reference model: registers as words with writable / W1C masks.
  logic [31:0] m_ctrl, m_txd, m_stat, m_rxd, m_div, m_rdata;
  logic        m_prev_busy, m_ts;

  function automatic logic [31:0] lanes(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] msk,
                                        input logic [3:0] b, input logic [31:0] x);
    logic [31:0] m;
    m = lanes(b) & msk;
    return (old & ~m) | (x & m);
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] a, input logic bz);
    case (a)
      6'd0:    return m_ctrl;
      6'd1:    return m_txd;
      6'd2:    return m_stat | {31'b0, bz};
      6'd3:    return m_rxd;
      6'd4:    return m_div;
      6'd5:    return VER;
      default: return 32'b0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] sets, clrs;
    logic        start;
    if (rst) begin
      m_ctrl = 0; m_txd = 0; m_stat = 0; m_rxd = 0; m_div = 32'd100; m_rdata = 0;
      m_prev_busy = 0; m_ts = 0;
      return;
    end
    start = wr && addr == 0 && be[0] && wd[0];
    if (rd) m_rdata = m_read(addr, busy);
    m_ts = start && !busy;
    sets = 0;
    if (m_prev_busy && !busy) sets[1] = 1;
    if (rxv) sets[2] = 1;
    if (rxv && m_stat[2]) sets[3] = 1;
    if (start && busy) sets[4] = 1;
    clrs = (wr && addr == 2) ? (lanes(be) & wd & 32'h1E) : 32'h0;
    if (rd && addr == 3) clrs[2] = 1;
    m_stat = (m_stat & ~clrs) | sets;
    if (wr && addr == 0) m_ctrl = merge(m_ctrl, 32'hE, be, wd);
    if (wr && addr == 1) m_txd  = merge(m_txd, 32'hFF, be, wd);
    if (wr && addr == 4) m_div  = merge(m_div, 32'hFFFF, be, wd);
    if (rxv) m_rxd = {24'b0, rxb};
    m_prev_busy = busy;
  endtask

  vec_t vq[$];

  initial begin
    // rst wr rd addr be data busy rxv rxb | rdata ts irq txbyte
    vq.push_back(v(1,0,0, 0,4'h0,32'h0, 0,0,8'h0, 32'h0,       0,0,8'h00));
    vq.push_back(v(1,0,0, 0,4'h0,32'h0, 0,0,8'h0, 32'h0,       0,0,8'h00));
    vq.push_back(v(0,0,1, 0,4'h0,32'h0, 0,0,8'h0, 32'h0,       0,0,8'h00));
    vq.push_back(v(0,0,1, 1,4'h0,32'h0, 0,0,8'h0, 32'h0,       0,0,8'h00));
    vq.push_back(v(0,0,1, 2,4'h0,32'h0, 0,0,8'h0, 32'h0,       0,0,8'h00));
    vq.push_back(v(0,0,1, 3,4'h0,32'h0, 0,0,8'h0, 32'h0,       0,0,8'h00));
    vq.push_back(v(0,0,1, 4,4'h0,32'h0, 0,0,8'h0, 32'd100,     0,0,8'h00));
    vq.push_back(v(0,0,1, 5,4'h0,32'h0, 0,0,8'h0, VER,         0,0,8'h00));
    vq.push_back(v(0,0,1,63,4'h0,32'h0, 0,0,8'h0, 32'h0,       0,0,8'h00));
    vq.push_back(v(0,1,0, 1,4'hF,32'h65,0,0,8'h0, 32'h0,       0,0,8'h65));
    vq.push_back(v(0,1,0, 0,4'h1,32'h1, 0,0,8'h0, 32'h0,       1,0,8'h65));
    vq.push_back(v(0,0,1, 0,4'h0,32'h0, 0,0,8'h0, 32'h0,       0,0,8'h65));
    vq.push_back(v(0,0,1, 1,4'h0,32'h0, 0,0,8'h0, 32'h65,      0,0,8'h65));
    vq.push_back(v(0,1,0, 4,4'h1,32'h1234,0,0,8'h0,32'h65,     0,0,8'h65));
    vq.push_back(v(0,0,1, 4,4'h0,32'h0, 0,0,8'h0, 32'h34,      0,0,8'h65));
    vq.push_back(v(0,1,0, 4,4'h3,32'h1234,0,0,8'h0,32'h34,     0,0,8'h65));
    vq.push_back(v(0,0,1, 4,4'h0,32'h0, 0,0,8'h0, 32'h1234,    0,0,8'h65));
    vq.push_back(v(0,1,0, 0,4'h1,32'h1, 1,0,8'h0, 32'h1234,    0,0,8'h65));
    vq.push_back(v(0,0,1, 2,4'h0,32'h0, 1,0,8'h0, 32'h11,      0,0,8'h65));
    vq.push_back(v(0,1,0, 2,4'h1,32'h10,1,0,8'h0, 32'h11,      0,0,8'h65));
    vq.push_back(v(0,0,1, 2,4'h0,32'h0, 1,0,8'h0, 32'h01,      0,0,8'h65));
    vq.push_back(v(0,1,0, 0,4'h1,32'h4, 1,0,8'h0, 32'h01,      0,0,8'h65));
    vq.push_back(v(0,0,0, 0,4'h0,32'h0, 0,0,8'h0, 32'h01,      0,1,8'h65));
    vq.push_back(v(0,0,1, 2,4'h0,32'h0, 0,0,8'h0, 32'h02,      0,1,8'h65));
    vq.push_back(v(0,1,0, 2,4'h1,32'h2, 0,0,8'h0, 32'h02,      0,0,8'h65));
    vq.push_back(v(0,1,0, 0,4'h1,32'h8, 0,0,8'h0, 32'h02,      0,0,8'h65));
    vq.push_back(v(0,0,0, 0,4'h0,32'h0, 0,1,8'hA5,32'h02,      0,1,8'h65));
    vq.push_back(v(0,0,1, 3,4'h0,32'h0, 0,0,8'h0, 32'hA5,      0,0,8'h65));
    vq.push_back(v(0,0,1, 2,4'h0,32'h0, 0,0,8'h0, 32'h00,      0,0,8'h65));
    vq.push_back(v(0,0,0, 0,4'h0,32'h0, 0,1,8'h11,32'h00,      0,1,8'h65));
    vq.push_back(v(0,0,0, 0,4'h0,32'h0, 0,1,8'h22,32'h00,      0,1,8'h65));
    vq.push_back(v(0,0,1, 2,4'h0,32'h0, 0,0,8'h0, 32'h0C,      0,1,8'h65));
    vq.push_back(v(0,0,1, 3,4'h0,32'h0, 0,0,8'h0, 32'h22,      0,0,8'h65));
    // RX arrival and RXDATA read in the same cycle: old data read, set wins.
    vq.push_back(v(0,0,1, 3,4'h0,32'h0, 0,1,8'h33,32'h22,      0,1,8'h65));
    vq.push_back(v(0,0,1, 2,4'h0,32'h0, 0,0,8'h0, 32'h0C,      0,1,8'h65));
    // Start then reset on the pulse cycle.
    vq.push_back(v(0,1,0, 0,4'h1,32'h9, 0,0,8'h0, 32'h0C,      1,1,8'h65));
    vq.push_back(v(1,0,0, 0,4'h0,32'h0, 0,0,8'h0, 32'h0,       0,0,8'h00));
    vq.push_back(v(0,0,1, 4,4'h0,32'h0, 0,0,8'h0, 32'd100,     0,0,8'h00));
    // Same-address read and write: read returns pre-write value.
    vq.push_back(v(0,1,1, 1,4'hF,32'h77,0,0,8'h0, 32'h0,       0,0,8'h77));
    vq.push_back(v(0,0,1, 1,4'h0,32'h0, 0,0,8'h0, 32'h77,      0,0,8'h77));

    @(negedge clk);
    foreach (vq[i]) begin
      rst = vq[i].rst; wr = vq[i].wr; rd = vq[i].rd; addr = vq[i].addr; be = vq[i].be;
      wd = vq[i].wd; busy = vq[i].busy; rxv = vq[i].rxv; rxb = vq[i].rxb;
      @(posedge clk); #1;
      check($sformatf("vec%0d rdata", i), rdata, vq[i].e_rd);
      check($sformatf("vec%0d txstart", i), {31'b0, txstart}, {31'b0, vq[i].e_ts});
      check($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vq[i].e_irq});
      check($sformatf("vec%0d txbyte", i), {24'b0, txbyte}, {24'b0, vq[i].e_txb});
    end

    // Randomized traffic against the reference model, starting from reset.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] r;
      r = $urandom;
      rst  = (c == 0) || (r[6:0] == 7'd0);
      wr   = ($urandom_range(0, 9) < 4);
      rd   = ($urandom_range(0, 9) < 5);
      addr = r[10] ? 6'($urandom) : 6'($urandom_range(0, 6));
      be   = 4'($urandom);
      wd   = r[11] ? $urandom : {27'b0, 5'($urandom)};
      if ($urandom_range(0, 9) == 0) busy = ~busy;
      rxv  = ($urandom_range(0, 9) < 2);
      rxb  = 8'($urandom);
      model_step();
      @(posedge clk); #1;
      check("rnd rdata", rdata, m_rdata);
      check("rnd txstart", {31'b0, txstart}, {31'b0, m_ts});
      check("rnd irq", {31'b0, irq},
            {31'b0, (m_stat[1] & m_ctrl[2]) | (m_stat[2] & m_ctrl[3])});
      check("rnd txbyte", {24'b0, txbyte}, m_txd);
      check("rnd enable", {31'b0, men}, {31'b0, m_ctrl[1]});
      check("rnd symdiv", {16'b0, sdiv}, m_div);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
